// File: rtl/fifo_rr_arbiter.sv
// Round-robin burst arbiter draining NUM_SRC source FIFOs into one destination FIFO.
// Optional FIFO_ARB_PRIO0_EN: source 0 wins every arbitration it takes part in.
module fifo_rr_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned SRC_BITS   = 2,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned BURST_BITS = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic [NUM_SRC-1:0]            i_src_empty,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] i_src_data,
  output logic [NUM_SRC-1:0]            o_src_rd_req,
  input  logic                          i_dst_afull,
  output logic                          o_dst_wr_req,
  output logic [DATA_WIDTH-1:0]         o_dst_data,
  output logic                          o_grant_valid,
  output logic [SRC_BITS-1:0]           o_grant_idx
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SRC_BITS-1:0]   r_grant_idx;
  logic [SRC_BITS-1:0]   w_grant_idx_nxt;
  logic [SRC_BITS-1:0]   r_last_grant;
  logic [SRC_BITS-1:0]   w_last_grant_nxt;
  logic [BURST_BITS-1:0] r_burst_cnt;
  logic [BURST_BITS-1:0] w_burst_cnt_nxt;
  logic                  r_grant_valid;
  logic                  w_grant_valid_nxt;
  logic                  r_rd_issued;
  logic [SRC_BITS-1:0]   r_rd_src;
  logic                  w_issue;
  logic                  w_sel_found;
  logic [SRC_BITS-1:0]   w_sel_idx;
  logic [SRC_BITS-1:0]   w_cand;

  // Pick the first non-empty source after the last grant, wrapping around.
  // With FIFO_ARB_PRIO0_EN, r_last_grant tracks only sources 1..NUM_SRC-1.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_cand      = '0;
`ifdef FIFO_ARB_PRIO0_EN
    if (!i_src_empty[0]) begin
      w_sel_found = 1'b1;
      w_sel_idx   = '0;
    end
`endif
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      w_cand = SRC_BITS'((32'(r_last_grant) + i) % NUM_SRC);
      if (!w_sel_found && !i_src_empty[w_cand]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand;
      end
    end
  end

  // Reads are withheld during reset so no source word is popped and lost.
  assign w_issue = (r_state == ST_BURST) && i_en && !i_rst && !i_dst_afull &&
                   !i_src_empty[r_grant_idx] &&
                   (r_burst_cnt < BURST_BITS'(MAX_BURST));

  always_comb begin
    o_src_rd_req = '0;
    if (w_issue) begin
      o_src_rd_req[r_grant_idx] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_idx_nxt   = r_grant_idx;
    w_last_grant_nxt  = r_last_grant;
    w_burst_cnt_nxt   = r_burst_cnt;
    w_grant_valid_nxt = r_grant_valid;
    case (r_state)
      ST_IDLE: begin
        if (i_en && w_sel_found) begin
          w_state_nxt       = ST_BURST;
          w_grant_idx_nxt   = w_sel_idx;
          w_burst_cnt_nxt   = '0;
          w_grant_valid_nxt = 1'b1;
`ifdef FIFO_ARB_PRIO0_EN
          if (w_sel_idx != '0) begin
            w_last_grant_nxt = w_sel_idx;
          end
`else
          w_last_grant_nxt = w_sel_idx;
`endif
        end
      end
      ST_BURST: begin
        if (w_issue) begin
          w_burst_cnt_nxt = r_burst_cnt + BURST_BITS'(1);
          if (r_burst_cnt == BURST_BITS'(MAX_BURST - 1)) begin
            w_state_nxt       = ST_IDLE;
            w_grant_valid_nxt = 1'b0;
          end
        end else if (i_en && !i_dst_afull) begin
          // Not paused and still no read: the granted source ran dry.
          w_state_nxt       = ST_IDLE;
          w_grant_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt       = ST_IDLE;
        w_grant_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_grant_idx   <= '0;
      r_last_grant  <= SRC_BITS'(NUM_SRC - 1);
      r_burst_cnt   <= '0;
      r_grant_valid <= 1'b0;
      r_rd_issued   <= 1'b0;
      r_rd_src      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant_idx   <= w_grant_idx_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_burst_cnt   <= w_burst_cnt_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_rd_issued   <= w_issue;
      r_rd_src      <= r_grant_idx;
    end
  end

  // Source data_out is valid one cycle after its read; forward it straight through.
  assign o_dst_wr_req  = r_rd_issued;
  assign o_dst_data    = r_rd_issued ?
                         i_src_data[32'(r_rd_src)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign o_grant_valid = r_grant_valid;
  assign o_grant_idx   = r_grant_idx;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter with behavioural source FIFOs and a destination log.
module tb_fifo_rr_arbiter;

  localparam int unsigned NS = 4;
  localparam int unsigned SB = 2;
  localparam int unsigned DW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             afull;
  logic [NS-1:0]    src_empty;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]    src_rd_req;
  logic             dst_wr_req;
  logic [DW-1:0]    dst_data;
  logic             grant_valid;
  logic [SB-1:0]    grant_idx;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(
    .NUM_SRC(NS), .SRC_BITS(SB), .DATA_WIDTH(DW), .MAX_BURST(8), .BURST_BITS(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_src_empty(src_empty), .i_src_data(src_data), .o_src_rd_req(src_rd_req),
    .i_dst_afull(afull), .o_dst_wr_req(dst_wr_req), .o_dst_data(dst_data),
    .o_grant_valid(grant_valid), .o_grant_idx(grant_idx)
  );

  logic [DW-1:0] q [NS][$];
  logic [DW-1:0] dout [NS];
  int            ld_cnt [NS];
  int            rd_next [16];
  logic [NS-1:0] tr_rd [$];
  logic          tr_gv [$];
  logic [SB-1:0] tr_gi [$];
  logic          tr_wr [$];
  logic [DW-1:0] tr_wd [$];
  logic [DW-1:0] dst_log [$];
  int            b_idx [$];
  int            b_len [$];
  int            gaps [$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            viol = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int s, input int k);
    return {4'(s), 12'(k)};
  endfunction

  task automatic refresh();
    for (int s = 0; s < NS; s++) begin
      src_empty[s] = (q[s].size() == 0);
      src_data[s*DW +: DW] = dout[s];
    end
  endtask

  task automatic load(input int s, input int n);
    for (int k = 0; k < n; k++) q[s].push_back(word(s, ld_cnt[s] + k));
    ld_cnt[s] += n;
    refresh();
  endtask

  function automatic bit all_empty();
    for (int s = 0; s < NS; s++) if (q[s].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: sample outputs mid-cycle, then apply the FIFO side effects of that cycle.
  task automatic cyc();
    logic [NS-1:0] rd;
    logic          wr;
    logic [DW-1:0] wd;
    #1;
    rd = src_rd_req; wr = dst_wr_req; wd = dst_data;
    tr_rd.push_back(rd); tr_gv.push_back(grant_valid); tr_gi.push_back(grant_idx);
    tr_wr.push_back(wr); tr_wd.push_back(wd);
    if ($countones(rd) > 1 || (rd != '0 && !grant_valid)) viol++;
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) begin
      if (rd[s]) begin
        if (q[s].size() == 0) viol++;
        else dout[s] = q[s].pop_front();
      end
    end
    if (wr) dst_log.push_back(wd);
    refresh();
  endtask

  task automatic clear_trace();
    tr_rd.delete(); tr_gv.delete(); tr_gi.delete(); tr_wr.delete(); tr_wd.delete();
    dst_log.delete();
  endtask

  task automatic drain(input string tag, input int max_c);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_c; i++) begin
      cyc();
      if (all_empty() && !tr_gv[$] && !tr_wr[$] && tr_rd[$] == '0) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_drained"}, 32'(done), 32'd1);
  endtask

  task automatic analyze();
    bit inb;
    int last;
    inb = 1'b0; last = -1;
    b_idx.delete(); b_len.delete(); gaps.delete();
    for (int i = 0; i < tr_gv.size(); i++) begin
      if (tr_gv[i]) begin
        if (!inb) begin
          inb = 1'b1;
          b_idx.push_back(int'(tr_gi[i]));
          b_len.push_back(0);
        end
        if (tr_rd[i] != '0) b_len[b_len.size()-1] = b_len[b_len.size()-1] + 1;
      end else begin
        inb = 1'b0;
      end
      if (tr_rd[i] != '0) begin
        if (last >= 0 && i - last > 1) gaps.push_back(i - last - 1);
        last = i;
      end
    end
  endtask

  task automatic check_bursts(input string tag, input int n, input int ei[8], input int el[8]);
    analyze();
    chk({tag, "_nbursts"}, 32'(b_idx.size()), 32'(n));
    for (int i = 0; i < n && i < b_idx.size(); i++) begin
      chk($sformatf("%s_idx%0d", tag, i), 32'(b_idx[i]), 32'(ei[i]));
      chk($sformatf("%s_len%0d", tag, i), 32'(b_len[i]), 32'(el[i]));
    end
  endtask

  task automatic check_order(input string tag, input int n);
    int bad;
    int s;
    int k;
    bad = 0;
    foreach (dst_log[i]) begin
      s = int'(dst_log[i][15:12]);
      k = int'(dst_log[i][11:0]);
      if (k != rd_next[s]) bad++;
      rd_next[s] = k + 1;
    end
    chk({tag, "_nwords"}, 32'(dst_log.size()), 32'(n));
    chk({tag, "_order"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int ei[8];
    int el[8];
    int refills;
    bit done;

    for (int s = 0; s < NS; s++) begin dout[s] = '0; ld_cnt[s] = 0; end
    for (int s = 0; s < 16; s++) rd_next[s] = 0;
    rst = 1'b1; en = 1'b1; afull = 1'b0; src_empty = '1; src_data = '0;
    refresh();

    // Reset state
    cyc(); cyc();
    chk("rst_gv", 32'(tr_gv[$]), 32'd0);
    chk("rst_gi", 32'(tr_gi[$]), 32'd0);
    chk("rst_rd", 32'(tr_rd[$]), 32'd0);
    chk("rst_wr", 32'(tr_wr[$]), 32'd0);
    chk("rst_data", 32'(tr_wd[$]), 32'd0);
    rst = 1'b0;
    cyc();
    chk("idle_all_empty_gv", 32'(tr_gv[$]), 32'd0);

    // Basic drain: 5 words from source 2
    clear_trace();
    load(2, 5);
    for (int i = 0; i < 8; i++) cyc();
    chk("t1_arb_rd", 32'(tr_rd[0]), 32'd0);
    chk("t1_grant_gv", 32'(tr_gv[1]), 32'd1);
    chk("t1_grant_idx", 32'(tr_gi[1]), 32'd2);
    for (int i = 1; i <= 5; i++) chk($sformatf("t1_rd%0d", i), 32'(tr_rd[i]), 32'h4);
    chk("t1_rd6", 32'(tr_rd[6]), 32'd0);
    chk("t1_wr1", 32'(tr_wr[1]), 32'd0);
    for (int i = 2; i <= 6; i++) begin
      chk($sformatf("t1_wr%0d", i), 32'(tr_wr[i]), 32'd1);
      chk($sformatf("t1_data%0d", i), 32'(tr_wd[i]), 32'(word(2, i - 2)));
    end
    chk("t1_wr7", 32'(tr_wr[7]), 32'd0);
    chk("t1_idle_gv", 32'(tr_gv[7]), 32'd0);
    check_order("t1", 5);

    // Burst cap and fairness: 20 words each in sources 0 and 1
    clear_trace();
    load(0, 20); load(1, 20);
    drain("t2", 200);
`ifdef FIFO_ARB_PRIO0_EN
    ei = '{0, 0, 0, 1, 1, 1, 0, 0}; el = '{8, 8, 4, 8, 8, 4, 0, 0};
    check_bursts("t2", 6, ei, el);
    ei = '{1, 1, 2, 1, 1, 0, 0, 0};
`else
    ei = '{0, 1, 0, 1, 0, 1, 0, 0}; el = '{8, 8, 8, 8, 4, 4, 0, 0};
    check_bursts("t2", 6, ei, el);
    ei = '{1, 1, 1, 1, 2, 0, 0, 0};
`endif
    chk("t2_ngaps", 32'(gaps.size()), 32'd5);
    for (int i = 0; i < 5 && i < gaps.size(); i++) chk($sformatf("t2_gap%0d", i), 32'(gaps[i]), 32'(ei[i]));
    check_order("t2", 40);

    // Backpressure on source 3
    clear_trace();
    load(3, 10);
    for (int i = 0; i < 4; i++) cyc();
    afull = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    afull = 1'b0;
    drain("t3", 100);
    for (int i = 4; i <= 7; i++) begin
      chk($sformatf("t3_hold_rd%0d", i), 32'(tr_rd[i]), 32'd0);
      chk($sformatf("t3_hold_gi%0d", i), 32'(tr_gi[i]), 32'd3);
      chk($sformatf("t3_hold_gv%0d", i), 32'(tr_gv[i]), 32'd1);
    end
    chk("t3_inflight_wr", 32'(tr_wr[4]), 32'd1);
    chk("t3_inflight_data", 32'(tr_wd[4]), 32'(word(3, 2)));
    chk("t3_paused_wr", 32'(tr_wr[5]), 32'd0);
    ei = '{3, 3, 0, 0, 0, 0, 0, 0}; el = '{8, 2, 0, 0, 0, 0, 0, 0};
    check_bursts("t3", 2, ei, el);
    check_order("t3", 10);

    // Enable pause mid-burst on source 1
    clear_trace();
    load(1, 12);
    for (int i = 0; i < 4; i++) cyc();
    en = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    en = 1'b1;
    drain("t4", 100);
    for (int i = 4; i <= 6; i++) begin
      chk($sformatf("t4_pause_rd%0d", i), 32'(tr_rd[i]), 32'd0);
      chk($sformatf("t4_pause_gv%0d", i), 32'(tr_gv[i]), 32'd1);
    end
    ei = '{1, 1, 0, 0, 0, 0, 0, 0}; el = '{8, 4, 0, 0, 0, 0, 0, 0};
    check_bursts("t4", 2, ei, el);
    check_order("t4", 12);

    // Reset mid-burst
    clear_trace();
    load(0, 6); load(2, 3);
    cyc(); cyc();
`ifdef FIFO_ARB_PRIO0_EN
    chk("t5_first_rd", 32'(tr_rd[1]), 32'h1);
`else
    chk("t5_first_rd", 32'(tr_rd[1]), 32'h4);
`endif
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("t5_rst_cycle_rd", 32'(tr_rd[2]), 32'd0);
    chk("t5_after_wr", 32'(tr_wr[3]), 32'd0);
    chk("t5_after_gv", 32'(tr_gv[3]), 32'd0);
    chk("t5_after_rd", 32'(tr_rd[3]), 32'd0);
    cyc();
    chk("t5_regrant_gv", 32'(tr_gv[4]), 32'd1);
    chk("t5_regrant_idx", 32'(tr_gi[4]), 32'd0);
    chk("t5_regrant_rd", 32'(tr_rd[4]), 32'h1);
    drain("t5", 100);
    check_order("t5", 9);

    // Arbitration order with sources 0, 1, 2 all loaded
    clear_trace();
    load(0, 3); load(1, 3); load(2, 3);
    refills = 0; done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc();
`ifdef FIFO_ARB_PRIO0_EN
      if (refills < 2 && q[0].size() == 0 && tr_rd[$] == '0 && tr_gv[$] && tr_gi[$] == '0) begin
        load(0, 3);
        refills++;
      end
`endif
      if (all_empty() && !tr_gv[$] && !tr_wr[$] && tr_rd[$] == '0) begin
        done = 1'b1;
        break;
      end
    end
    chk("t6_drained", 32'(done), 32'd1);
`ifdef FIFO_ARB_PRIO0_EN
    ei = '{0, 0, 0, 1, 2, 0, 0, 0}; el = '{3, 3, 3, 3, 3, 0, 0, 0};
    check_bursts("t6", 5, ei, el);
    check_order("t6", 15);
`else
    ei = '{0, 1, 2, 0, 0, 0, 0, 0}; el = '{3, 3, 3, 0, 0, 0, 0, 0};
    check_bursts("t6", 3, ei, el);
    check_order("t6", 9);
`endif

    chk("onehot_and_no_underflow", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
